// File: rtl/control_sequencer.sv
// Multi-cycle control FSM for the 16-bit accumulator CPU: sequences fetch,
// decode, execute and memory phases, drives datapath strobes and the memory handshake.
module control_sequencer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_program,
  input  logic [3:0]       OP_code,
  input  logic             acc_zero,
  input  logic             acc_neg,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             acc_load,
  output logic [1:0]       acc_src,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_PAUSE  = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                fault_q, fault_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                retire;
  logic                waiting;
  state_t              boundary;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    acc_load = 1'b0;
    acc_src  = 2'd0;
    alu_op   = 3'b111;
    halted   = 1'b0;
    retire   = 1'b0;
    boundary = halt_program ? S_PAUSE : S_FETCH;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (OP_code)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: state_d = S_MEM;
          4'hF: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        retire  = 1'b1;
        state_d = boundary;
        case (OP_code)
          4'h7: begin acc_load = 1'b1; alu_op = 3'b100; end
          4'hC: begin acc_load = 1'b1; alu_op = 3'b101; end
          4'hD: begin acc_load = 1'b1; alu_op = 3'b110; end
          4'h8: begin acc_load = 1'b1; acc_src = 2'd2; end
          4'h9: pc_load = 1'b1;
          4'hA: pc_load = acc_zero;
          4'hB: pc_load = acc_neg;
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (OP_code == 4'h2);
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = boundary;
          case (OP_code)
            4'h1: begin acc_load = 1'b1; acc_src = 2'd1; end
            4'h3: begin acc_load = 1'b1; alu_op = 3'b000; end
            4'h4: begin acc_load = 1'b1; alu_op = 3'b001; end
            4'h5: begin acc_load = 1'b1; alu_op = 3'b010; end
            4'h6: begin acc_load = 1'b1; alu_op = 3'b011; end
            default: ;
          endcase
        end
      end
      S_PAUSE: if (!halt_program) state_d = S_FETCH;
      S_HALT:  halted = 1'b1;
      S_FAULT: ;
      default: state_d = S_FETCH;
    endcase

    // A request stuck for WAIT_MAX consecutive cycles overrides any other transition.
    waiting = mem_req && !mem_ready;
    fault_d = fault_q;
    if (waiting && (wait_q == WAIT_W'(WAIT_MAX - 1))) begin
      state_d = S_FAULT;
      fault_d = 1'b1;
    end
    wait_d = (waiting && (state_d == state_q)) ? wait_q + WAIT_W'(1) : '0;

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      ir_load  = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      acc_load = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: hand-computed expectations
// for sequencing, memory waits, pause/halt and the memory-timeout fault.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_program;
  logic [3:0]  op_code;
  logic        acc_zero;
  logic        acc_neg;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, acc_load;
  logic [1:0]  acc_src;
  logic [2:0]  alu_op;
  logic        halted, fault;
  logic [2:0]  state;
  logic [15:0] retired;

  int checks   = 0;
  int failures = 0;

  control_sequencer #(.WAIT_MAX(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .halt_program(halt_program), .OP_code(op_code),
    .acc_zero(acc_zero), .acc_neg(acc_neg), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .acc_load(acc_load), .acc_src(acc_src),
    .alu_op(alu_op), .halted(halted), .fault(fault), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land just after the edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; halt_program = 1'b0; op_code = 4'h0;
    acc_zero = 1'b0; acc_neg = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    #1;
    check("rst_state",   32'(state),   32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_fault",   32'(fault),   32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_ir_load", 32'(ir_load), 32'd0);

    // LOADI stream with zero-wait memory: FETCH, DECODE, EXEC repeating.
    rst = 1'b0; op_code = 4'h8;
    for (int i = 0; i < 9; i++) begin
      #1;
      check("loadi_state", 32'(state), 32'(i % 3));
      if (i % 3 == 0) begin
        check("loadi_fetch_req",  32'(mem_req),  32'd1);
        check("loadi_fetch_addr", 32'(addr_sel), 32'd0);
        check("loadi_pc_inc",     32'(pc_inc),   32'd1);
        check("loadi_ir_load",    32'(ir_load),  32'd1);
      end
      if (i % 3 == 2) begin
        check("loadi_acc_load", 32'(acc_load), 32'd1);
        check("loadi_acc_src",  32'(acc_src),  32'd2);
        check("loadi_no_inc",   32'(pc_inc),   32'd0);
      end
      tick();
    end
    #1;
    check("loadi_retired", 32'(retired), 32'd3);

    // ADD with two memory wait cycles.
    op_code = 4'h3;
    tick();
    #1;
    check("add_decode", 32'(state), 32'd1);
    check("add_decode_req", 32'(mem_req), 32'd0);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("add_wait_state",   32'(state),    32'd3);
      check("add_wait_req",     32'(mem_req),  32'd1);
      check("add_wait_addr",    32'(addr_sel), 32'd1);
      check("add_wait_acc",     32'(acc_load), 32'd0);
      check("add_wait_alu_op",  32'(alu_op == 3'b000), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("add_ready_req",   32'(mem_req),  32'd1);
    check("add_ready_acc",   32'(acc_load), 32'd1);
    check("add_ready_src",   32'(acc_src),  32'd0);
    check("add_ready_alu",   32'(alu_op),   32'd0);
    check("add_ready_we",    32'(mem_we),   32'd0);
    tick();
    #1;
    check("add_retired", 32'(retired), 32'd4);
    check("add_back_fetch", 32'(state), 32'd0);

    // STORE with one wait cycle.
    op_code = 4'h2;
    tick(); tick();
    mem_ready = 1'b0;
    #1;
    check("store_state", 32'(state),    32'd3);
    check("store_we_w",  32'(mem_we),   32'd1);
    check("store_acc_w", 32'(acc_load), 32'd0);
    tick();
    mem_ready = 1'b1;
    #1;
    check("store_we_r",  32'(mem_we),   32'd1);
    check("store_acc_r", 32'(acc_load), 32'd0);
    tick();
    #1;
    check("store_retired", 32'(retired), 32'd5);

    // JZ not taken, then taken.
    op_code = 4'hA; acc_zero = 1'b0;
    #1;
    check("jz_fetch_inc",  32'(pc_inc),  32'd1);
    check("jz_fetch_load", 32'(pc_load), 32'd0);
    tick();
    #1;
    check("jz_decode_inc", 32'(pc_inc), 32'd0);
    tick();
    #1;
    check("jz0_state",   32'(state),   32'd2);
    check("jz0_pc_load", 32'(pc_load), 32'd0);
    check("jz0_pc_inc",  32'(pc_inc),  32'd0);
    tick();
    acc_zero = 1'b1;
    tick(); tick();
    #1;
    check("jz1_pc_load", 32'(pc_load), 32'd1);
    check("jz1_pc_inc",  32'(pc_inc),  32'd0);
    tick();
    #1;
    check("jz_retired", 32'(retired), 32'd7);

    // LOAD whose wait is interrupted by a pause request.
    op_code = 4'h1;
    tick(); tick();
    mem_ready = 1'b0; halt_program = 1'b1;
    #1;
    check("pause_mem_state", 32'(state), 32'd3);
    tick();
    #1;
    check("pause_mem_held", 32'(state), 32'd3);
    mem_ready = 1'b1;
    #1;
    check("load_acc", 32'(acc_load), 32'd1);
    check("load_src", 32'(acc_src),  32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("pause_state", 32'(state),   32'd4);
      check("pause_req",   32'(mem_req), 32'd0);
      tick();
    end
    halt_program = 1'b0;
    #1;
    check("pause_drop_state", 32'(state), 32'd4);
    check("pause_retired",    32'(retired), 32'd8);
    tick();
    #1;
    check("resume_fetch", 32'(state), 32'd0);

    // HALT opcode: terminal, retires once.
    op_code = 4'hF;
    tick();
    #1;
    check("halt_decode", 32'(state), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("halt_state",   32'(state),   32'd5);
      check("halt_flag",    32'(halted),  32'd1);
      check("halt_retired", 32'(retired), 32'd9);
      check("halt_req",     32'(mem_req), 32'd0);
      tick();
    end

    // Reset out of HALT, then abort a pending fetch with reset.
    rst = 1'b1;
    tick();
    #1;
    check("rst2_state",   32'(state),   32'd0);
    check("rst2_retired", 32'(retired), 32'd0);
    check("rst2_halted",  32'(halted),  32'd0);
    rst = 1'b0; mem_ready = 1'b0; op_code = 4'h8;
    #1;
    check("abort_req_before", 32'(mem_req), 32'd1);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("abort_req_in_rst", 32'(mem_req), 32'd0);
    check("abort_ir_in_rst",  32'(ir_load), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("abort_restart_state", 32'(state),   32'd0);
    check("abort_restart_req",   32'(mem_req), 32'd1);

    // Memory timeout: 15 waiting cycles in FETCH.
    for (int i = 0; i < 14; i++) tick();
    #1;
    check("timeout_edge_state", 32'(state), 32'd0);
    check("timeout_edge_fault", 32'(fault), 32'd0);
    tick();
    #1;
    check("timeout_state", 32'(state),   32'd6);
    check("timeout_fault", 32'(fault),   32'd1);
    check("timeout_req",   32'(mem_req), 32'd0);
    mem_ready = 1'b1;
    tick(); tick();
    #1;
    check("fault_sticky_state", 32'(state), 32'd6);
    check("fault_sticky_flag",  32'(fault), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst3_state",   32'(state),   32'd0);
    check("rst3_fault",   32'(fault),   32'd0);
    check("rst3_retired", 32'(retired), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
